// File: rtl/node_mem_pkg.sv
// Shared definitions for the node data memory: geometry, arbiter state encoding
// and the word addresses the RL sub-blocks agree on.
package node_mem_pkg;

    localparam int ADDR_W    = 11;
    localparam int WORD_W    = 16;
    localparam int MEM_DEPTH = 2048;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } arb_state_t;

    localparam logic [ADDR_W-1:0] KNOWN_CH_COUNT_ADDR   = 11'h272;
    localparam logic [ADDR_W-1:0] NEIGHBOR_COUNT_ADDR   = 11'h274;
    localparam logic [ADDR_W-1:0] NEIGHBOR_CLUSTER_BASE = 11'h0B2;
    localparam logic [ADDR_W-1:0] NEIGHBOR_Q_BASE       = 11'h132;
    localparam logic [ADDR_W-1:0] NEIGHBOR_ID_BASE      = 11'h072;

endpackage

// File: rtl/node_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping, as a one-hot vector plus its index.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        logic [IDX_W-1:0] j;
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IDX_W'((int'(ptr) + k) % N);
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/node_mem_arbiter.sv
// Round-robin owner arbitration for the single-port node data memory: one
// requester at a time drives the port, read data returns with a per-owner valid.
module node_mem_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = node_mem_pkg::ADDR_W,
    parameter int WORD_W   = node_mem_pkg::WORD_W,
    parameter int MAX_HOLD = 64
) (
    input  logic                    clock,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_wr_en,
    input  logic [N_REQ*WORD_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [WORD_W-1:0]       rdata,
    output logic [N_REQ-1:0]        rvalid,
    output logic                    preempt,
    output logic                    addr_err,
    output logic                    mem_en,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_wr_en,
    output logic [WORD_W-1:0]       mem_wdata,
    input  logic [WORD_W-1:0]       mem_rdata
);
    import node_mem_pkg::*;

    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  owner, owner_nxt;
    logic [IDX_W-1:0]  ptr, ptr_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              preempt_nxt;
    logic [N_REQ-1:0]  rd_pend, rd_pend_nxt;

    logic [N_REQ-1:0]  pick;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    logic              fwd;
    logic              others_waiting;
    logic [ADDR_W-1:0] own_addr;
    logic [WORD_W-1:0] own_wdata;
    logic              own_wr;
    logic [IDX_W-1:0]  owner_inc;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign own_addr       = req_addr[int'(owner)*ADDR_W +: ADDR_W];
    assign own_wdata      = req_wdata[int'(owner)*WORD_W +: WORD_W];
    assign own_wr         = req_wr_en[owner];
    assign fwd            = (state == S_OWN) && req[owner];
    assign others_waiting = |(req & ~gnt);
    assign owner_inc      = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);

    // The owner's access goes straight to the port in the cycle it is presented.
    always_comb begin
        mem_en    = 1'b0;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        if (fwd) begin
            mem_en    = 1'b1;
            mem_addr  = {own_addr[ADDR_W-1:1], 1'b0};
            mem_wr_en = own_wr;
            mem_wdata = own_wdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        ptr_nxt     = ptr;
        gnt_nxt     = gnt;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        rd_pend_nxt = '0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    state_nxt = S_OWN;
                    owner_nxt = pick_idx;
                    gnt_nxt   = pick;
                    hold_nxt  = '0;
                end
            end
            S_OWN: begin
                if (!req[owner]) begin
                    state_nxt = S_IDLE;
                    gnt_nxt   = '0;
                    ptr_nxt   = owner_inc;
                end else begin
                    if (!own_wr)
                        rd_pend_nxt = gnt;
                    if (hold_cnt < HOLD_MAX)
                        hold_nxt = hold_cnt + HOLD_W'(1);
                    // The access that reaches the limit still completes; the owner leaves after it.
                    if (hold_cnt >= HOLD_LAST && others_waiting) begin
                        state_nxt   = S_IDLE;
                        gnt_nxt     = '0;
                        ptr_nxt     = owner_inc;
                        preempt_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            // NOTE: rdata is reset along with control state because it is a visible port with a defined reset value.
            state    <= S_IDLE;
            owner    <= '0;
            ptr      <= '0;
            gnt      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
            rd_pend  <= '0;
            rvalid   <= '0;
            rdata    <= '0;
            addr_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            owner    <= owner_nxt;
            ptr      <= ptr_nxt;
            gnt      <= gnt_nxt;
            hold_cnt <= hold_nxt;
            preempt  <= preempt_nxt;
            rd_pend  <= rd_pend_nxt;
            rvalid   <= rd_pend;
            if (|rd_pend)
                rdata <= mem_rdata;
            if (fwd && own_addr[0])
                addr_err <= 1'b1;
        end
    end

endmodule
